pingpong_buffer_filler: RTL and testbench
=========================================

Name: pingpong_buffer_filler

Overview:
- Upstream producer for the I2S output stage.
- Takes the byte stream from the storage reader through a valid/ready handshake and assembles little-endian 16-bit samples.
- Writes the samples into a two-bank ping-pong sample RAM.
- Tells the I2S stage when the bank it reads next is full. The I2S stage hands banks back through its buffer-empty flag, which runs on the BCLK domain.

Parameters:
- BUFFER_ADDR_BITS, 9, word address width of one bank.
- BUFFER_WORDS, 512, 16-bit words per bank. Must be ≤ 2**BUFFER_ADDR_BITS and even.

Ports:
- master_clock  in  1  system clock, 203.2128 MHz, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- src_data  in  8  byte from storage reader.
- src_valid  in  1  src_data valid.
- src_ready  out  1  byte accepted when src_valid & src_ready.
- buffer_empty_i  in  1  bank release flag from I2S stage. Asynchronous (BCLK domain); level, rising edge = release.
- wr_en  out  1  RAM write strobe, one cycle per word.
- wr_bank  out  1  bank being written.
- wr_addr  out  BUFFER_ADDR_BITS  word address within wr_bank.
- wr_data  out  16  sample word {hi_byte, lo_byte}.
- buffer_filled_o  out  1  registered; bank the I2S stage reads next is full.
- underrun_o  out  1  sticky; a release occurred while the next bank was not full.

Behaviour:
- Reset values (async, immediate on reset_n low):
  - state = S_STALL, full[1:0] = 00, wr_bank = 0, rd_bank = 0, wr_addr = 0.
  - wr_en = 0, wr_data = 0, src_ready = 0, buffer_filled_o = 0, underrun_o = 0, sync flops = 0.
- States:
  - S_LO: src_ready = 1. On handshake, latch lo byte, go to S_HI.
  - S_HI: src_ready = 1. On handshake, latch hi byte, go to S_WR.
  - S_WR: src_ready = 0; wr_en = 1 with wr_data = {hi, lo}, wr_addr, wr_bank.
    - If wr_addr != BUFFER_WORDS-1: wr_addr++ and go to S_LO.
    - Else: set full[wr_bank], toggle wr_bank, wr_addr = 0, go to S_STALL.
  - S_STALL: src_ready = 0. Go to S_LO in the first cycle where full[wr_bank] == 0.
- After reset, the first cycle goes S_STALL → S_LO, so src_ready rises one cycle after reset release.
- Latency: second byte handshake in cycle N → wr_en in cycle N+1. Peak throughput: 1 word per 3 cycles.
- Release path:
  - buffer_empty_i passes through a 2-FF synchronizer, then a rising-edge detect register.
  - A release event clears full[rd_bank] and toggles rd_bank, three master_clock edges after buffer_empty_i is first sampled high.
  - A release on the same cycle as the S_WR fill completion: both updates apply; they never touch the same bank bit.
  - A release with full[rd_bank] == 0 (spurious) only toggles rd_bank and sets underrun_o.
- underrun_o is set when a release event occurs and full[~rd_bank] == 0. It is cleared only by reset.
- buffer_filled_o is registered: next value = full[rd_bank] using post-update state. It is held stable for many BCLK periods so the I2S stage can sample it safely.
- A source stall (src_valid low) in S_LO/S_HI holds state indefinitely; no timeout.
- Reset mid-fill discards the partial word and all bank contents flags; refill restarts at bank 0, address 0.

Optional Feature:
- Macro MONO_DUP_EN.
  - Defined: the source is mono. Each assembled sample is written twice to consecutive addresses (L and R slots). S_WR is followed by S_DUP (wr_en = 1, same wr_data, wr_addr+1, src_ready = 0). The bank-full check is done in S_DUP, with the same rules as S_WR. A pair never straddles banks because BUFFER_WORDS is even.
  - Undefined: the source is interleaved stereo, each sample is written once, and S_DUP does not exist.

Test Plan:
- Reset, then stream bytes 0x00,0x01,0x02… continuously → wr_data 0x0100 @ bank0/addr0, 0x0302 @ addr1, …. After 512 words: buffer_filled_o = 1, wr_bank = 1, wr_addr = 0.
- Fill both banks (2048 bytes) → src_ready = 0, full = 11. Raise buffer_empty_i for 20 cycles → buffer_filled_o stays 1 (bank1 full), rd_bank = 1, src_ready returns within 5 cycles, and the next write goes to bank0/addr0.
- Toggle src_valid on random cycles through 1024 bytes → every word equals {byte[2k+1], byte[2k]}; no extra or missing wr_en.
- Fill bank0 only, then release it while bank1 holds 100 words → underrun_o = 1, buffer_filled_o = 0; later fill completion of bank1 → buffer_filled_o = 1.
- Drop reset_n at word 100 of bank0 → all outputs 0 asynchronously. After release, bytes 0xAA,0x55 → wr_data 0x55AA @ bank0/addr0.
- MONO_DUP_EN defined: bytes 0x34,0x12 → two consecutive wr_en cycles writing 0x1234 to addr0 and addr1. Bank full after 256 samples.

Source files
------------

// File: rtl/pingpong_buffer_filler.sv
// pingpong_buffer_filler: assembles little-endian 16-bit samples from a byte stream into a two-bank ping-pong sample RAM
// Ports:
//   master_clock, reset_n          clock, async active-low reset
//   src_data/src_valid/src_ready   byte stream from the storage reader (valid/ready)
//   buffer_empty_i                 async bank-release level from the I2S stage (rising edge = release)
//   wr_en/wr_bank/wr_addr/wr_data  RAM write port, one strobe per word
//   buffer_filled_o                registered: bank the I2S stage reads next is full
//   underrun_o                     sticky: a release found the next bank not full
// Build option: MONO_DUP_EN writes every assembled sample twice (L and R slots).
module pingpong_buffer_filler #(
  parameter int BUFFER_ADDR_BITS = 9,
  parameter int BUFFER_WORDS     = 512
) (
  input  logic                        master_clock,
  input  logic                        reset_n,
  input  logic [7:0]                  src_data,
  input  logic                        src_valid,
  output logic                        src_ready,
  input  logic                        buffer_empty_i,
  output logic                        wr_en,
  output logic                        wr_bank,
  output logic [BUFFER_ADDR_BITS-1:0] wr_addr,
  output logic [15:0]                 wr_data,
  output logic                        buffer_filled_o,
  output logic                        underrun_o
);
`ifdef MONO_DUP_EN
  typedef enum logic [2:0] {S_STALL, S_LO, S_HI, S_WR, S_DUP} state_t;
`else
  typedef enum logic [1:0] {S_STALL, S_LO, S_HI, S_WR} state_t;
`endif
  localparam logic [BUFFER_ADDR_BITS-1:0] LAST = BUFFER_ADDR_BITS'(BUFFER_WORDS - 1);
  localparam logic [BUFFER_ADDR_BITS-1:0] ONE  = BUFFER_ADDR_BITS'(1);
  state_t                      state_q, state_d;
  logic [BUFFER_ADDR_BITS-1:0] addr_q, addr_d;
  logic                        bank_q, bank_d;
  logic [7:0]                  lo_q, lo_d;
  logic [15:0]                 data_q, data_d;
  logic [1:0]                  full_q, full_d;
  logic                        rd_q, rd_d;
  logic                        under_q, under_d;
  logic                        filled_q, filled_d;
  logic                        sync1_q, sync2_q, prev_q;
  logic                        ready_q, wr_en_q;
  logic                        hs, rel, fill;
  assign hs              = src_valid & ready_q;
  assign rel             = sync2_q & ~prev_q;
  assign src_ready       = ready_q;
  assign wr_en           = wr_en_q;
  assign wr_bank         = bank_q;
  assign wr_addr         = addr_q;
  assign wr_data         = data_q;
  assign buffer_filled_o = filled_q;
  assign underrun_o      = under_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bank_d  = bank_q;
    lo_d    = lo_q;
    data_d  = data_q;
    fill    = 1'b0;
    case (state_q)
      S_STALL: state_d = full_q[bank_q] ? S_STALL : S_LO;
      S_LO: if (hs) begin
        lo_d    = src_data;
        state_d = S_HI;
      end
      S_HI: if (hs) begin
        data_d  = {src_data, lo_q};
        state_d = S_WR;
      end
      default: begin
`ifdef MONO_DUP_EN
        // first copy of a pair can never be the last word of a bank (even bank size)
        if (state_q == S_WR) begin
          addr_d  = addr_q + ONE;
          state_d = S_DUP;
        end else
`endif
        if (addr_q == LAST) begin
          fill    = 1'b1;
          bank_d  = ~bank_q;
          addr_d  = '0;
          state_d = S_STALL;
        end else begin
          addr_d  = addr_q + ONE;
          state_d = S_LO;
        end
      end
    endcase
    // fill completion and release never target the same bank in normal operation
    full_d = full_q;
    if (rel) full_d[rd_q] = 1'b0;
    if (fill) full_d[bank_q] = 1'b1;
    rd_d     = rd_q ^ rel;
    // a release is an underrun if the bank handed back was not full or the next one is not ready
    under_d  = under_q | (rel & ~(full_q[rd_q] & full_q[~rd_q]));
    filled_d = full_d[rd_d];
  end
  always_ff @(posedge master_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_STALL;
      addr_q   <= '0;
      bank_q   <= 1'b0;
      lo_q     <= '0;
      data_q   <= '0;
      full_q   <= '0;
      rd_q     <= 1'b0;
      under_q  <= 1'b0;
      filled_q <= 1'b0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      ready_q  <= 1'b0;
      wr_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      bank_q   <= bank_d;
      lo_q     <= lo_d;
      data_q   <= data_d;
      full_q   <= full_d;
      rd_q     <= rd_d;
      under_q  <= under_d;
      filled_q <= filled_d;
      sync1_q  <= buffer_empty_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      ready_q  <= state_d inside {S_LO, S_HI};
      wr_en_q  <= !(state_d inside {S_STALL, S_LO, S_HI});
    end
  end
endmodule

// File: tb/tb_pingpong_buffer_filler.sv
// tb_pingpong_buffer_filler: randomized/directed bench with a sample-stream reference model
module tb_pingpong_buffer_filler;
  localparam int AB = 9;
  localparam int W  = 512;
`ifdef MONO_DUP_EN
  localparam int REP = 2;
`else
  localparam int REP = 1;
`endif
  localparam int BANK_BYTES = 2 * W / REP;
  logic          master_clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    src_data = '0;
  logic          src_valid = 1'b0;
  logic          buffer_empty_i = 1'b0;
  logic          src_ready, wr_en, wr_bank, buffer_filled_o, underrun_o;
  logic [AB-1:0] wr_addr;
  logic [15:0]   wr_data;
  int            vecs = 0;
  int            errs = 0;
  int            n_writes = 0;
  int            first;
  logic [7:0]    q[$];
  bit [1:0]      m_full;
  bit            m_rd, m_under, rnd_valid, rnd_data, hs;
  logic [7:0]    nxt;
  always #5 master_clock = ~master_clock;
  pingpong_buffer_filler #(.BUFFER_ADDR_BITS(AB), .BUFFER_WORDS(W)) dut (
    .master_clock(master_clock), .reset_n(reset_n), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .buffer_empty_i(buffer_empty_i), .wr_en(wr_en), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_data(wr_data), .buffer_filled_o(buffer_filled_o), .underrun_o(underrun_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    n_writes = 0;
    m_full   = '0;
    m_rd     = 1'b0;
    m_under  = 1'b0;
  endtask
  // word k of the stream is {byte[2k+1], byte[2k]}, written REP times at consecutive positions
  task automatic monitor();
    int k, b;
    if (!reset_n) return;
    if (src_valid && src_ready) q.push_back(src_data);
    if (wr_en) begin
      k = n_writes / REP;
      b = (n_writes / W) % 2;
      if (q.size() < 2 * k + 2) chk("wr_extra", 32'(q.size()), 32'(2 * k + 2));
      else chk("wr_data", 32'(wr_data), 32'({q[2*k+1], q[2*k]}));
      chk("wr_bank", 32'(wr_bank), 32'(b));
      chk("wr_addr", 32'(wr_addr), 32'(n_writes % W));
      chk("wr_into_full", 32'(m_full[b]), 32'(0));
      n_writes++;
      if (n_writes % W == 0) m_full[b] = 1'b1;
    end
  endtask
  task automatic cycle(output bit h);
    @(negedge master_clock);
    h = reset_n && src_valid && src_ready;
    monitor();
    @(posedge master_clock);
    #1;
  endtask
  task automatic send(input int n);
    int cnt, budget;
    bit h;
    cnt = 0;
    budget = 0;
    src_data = nxt;
    while (cnt < n && budget < 6 * n + 50) begin
      src_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle(h);
      budget++;
      if (h) begin
        cnt++;
        nxt = rnd_data ? 8'($urandom) : nxt + 8'd1;
        src_data = nxt;
      end
    end
    src_valid = 1'b0;
    chk("send_count", 32'(cnt), 32'(n));
  endtask
  task automatic chk_quiet();
    chk("filled", 32'(buffer_filled_o), 32'(m_full[m_rd]));
    chk("underrun", 32'(underrun_o), 32'(m_under));
    chk("idle_bank", 32'(wr_bank), 32'((n_writes / W) % 2));
    chk("idle_addr", 32'(wr_addr), 32'(n_writes % W));
  endtask
  task automatic release_bank(output int f);
    bit h;
    f = 99;
    buffer_empty_i = 1'b1;
    m_under = m_under | !(m_full[m_rd] && m_full[!m_rd]);
    m_full[m_rd] = 1'b0;
    m_rd = !m_rd;
    for (int i = 1; i <= 20; i++) begin
      cycle(h);
      if (src_ready && f == 99) f = i;
    end
    buffer_empty_i = 1'b0;
    repeat (3) cycle(h);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(src_ready), 0);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_bank"}, 32'(wr_bank), 0);
    chk({tag, "_addr"}, 32'(wr_addr), 0);
    chk({tag, "_data"}, 32'(wr_data), 0);
    chk({tag, "_filled"}, 32'(buffer_filled_o), 0);
    chk({tag, "_underrun"}, 32'(underrun_o), 0);
  endtask
  task automatic do_reset();
    bit h;
    reset_n = 1'b0;
    src_valid = 1'b0;
    buffer_empty_i = 1'b0;
    model_reset();
    repeat (2) cycle(h);
    chk_zero("rst");
    reset_n = 1'b1;
    chk("ready_at_release", 32'(src_ready), 0);
    cycle(h);
    chk("ready_after_1", 32'(src_ready), 1);
  endtask
  initial begin
    nxt = 8'h00;
    rnd_valid = 1'b0;
    rnd_data = 1'b0;
    do_reset();
    send(BANK_BYTES);
    repeat (3) cycle(hs);
    chk_quiet();
    chk("bank0_filled", 32'(buffer_filled_o), 1);
    send(BANK_BYTES);
    repeat (3) cycle(hs);
    chk_quiet();
    src_valid = 1'b1;
    src_data = nxt;
    repeat (6) begin
      cycle(hs);
      chk("stall_hs", 32'(hs), 0);
    end
    src_valid = 1'b0;
    release_bank(first);
    chk("resume_latency", 32'(first <= 5), 1);
    chk_quiet();
    rnd_valid = 1'b1;
    rnd_data = 1'b1;
    send(BANK_BYTES);
    rnd_valid = 1'b0;
    rnd_data = 1'b0;
    repeat (3) cycle(hs);
    chk_quiet();
    chk("s3_writes", 32'(n_writes), 32'(3 * W));
    release_bank(first);
    chk_quiet();
    send(100 * 2 / REP);
    repeat (3) cycle(hs);
    release_bank(first);
    chk_quiet();
    chk("s4_underrun", 32'(underrun_o), 1);
    chk("s4_not_filled", 32'(buffer_filled_o), 0);
    send((W - 100) * 2 / REP);
    repeat (3) cycle(hs);
    chk_quiet();
    chk("s4_filled", 32'(buffer_filled_o), 1);
    send(100 * 2 / REP);
    #2 reset_n = 1'b0;
    #1 chk_zero("async");
    do_reset();
    nxt = 8'hAA;
    send(1);
    nxt = 8'h55;
    send(1);
    chk("first_wr_en", 32'(wr_en), 1);
    chk("first_data", 32'(wr_data), 32'h55AA);
    chk("first_addr", 32'(wr_addr), 0);
    chk("first_bank", 32'(wr_bank), 0);
    repeat (3) cycle(hs);
    chk("final_writes", 32'(n_writes), 32'(REP));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
